// File: rtl/camera_capture.sv
// camera_capture: samples an asynchronous DVP-style camera bus on inclk,
// pairs bytes into RGB565 pixels and tracks line/frame geometry errors.
module camera_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        inclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        apclk,
  input  logic        ahref,
  input  logic        avsync,
  input  logic [7:0]  adata,
  input  logic        err_clr,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_end,
  output logic        err_line,
  output logic        err_frame
);

  // state     | meaning
  // WAIT_SYNC | after reset; wait for avsync rise so capture never starts mid-frame
  // BLANK     | vertical blanking; arm on avsync fall when enable=1
  // ACTIVE    | capturing lines of the current frame
  localparam logic [1:0] WAIT_SYNC = 2'd0;
  localparam logic [1:0] BLANK     = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       href_s1_q, href_s2_q, href_s3_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0] data_s1_q, data_s2_q;

  logic [1:0]  state_q, state_d;
  logic        tog_q, tog_d;
  logic [7:0]  hi_q, hi_d;
  logic [9:0]  pix_cnt_q, pix_cnt_d;
  logic [8:0]  line_cnt_q, line_cnt_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic        fs_q, fs_d, fe_q, fe_d, le_q, le_d;
  logic        err_line_q, err_line_d, err_frame_q, err_frame_d;

  logic       pclk_rise, href_rise, href_fall, vs_rise, vs_fall;
  logic       tog_cur;
  logic [9:0] pix_cnt_cur;
  logic       set_err_line, set_err_frame;

  // Two-flop synchronizers plus a third stage for edge detection.
  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      {pclk_s1_q, pclk_s2_q, pclk_s3_q} <= 3'b000;
      {href_s1_q, href_s2_q, href_s3_q} <= 3'b000;
      {vs_s1_q, vs_s2_q, vs_s3_q}       <= 3'b000;
      data_s1_q <= 8'h00;
      data_s2_q <= 8'h00;
    end else begin
      {pclk_s1_q, pclk_s2_q, pclk_s3_q} <= {apclk, pclk_s1_q, pclk_s2_q};
      {href_s1_q, href_s2_q, href_s3_q} <= {ahref, href_s1_q, href_s2_q};
      {vs_s1_q, vs_s2_q, vs_s3_q}       <= {avsync, vs_s1_q, vs_s2_q};
      data_s1_q <= adata;
      data_s2_q <= data_s1_q;
    end
  end

  assign pclk_rise = pclk_s2_q & ~pclk_s3_q;
  assign href_rise = href_s2_q & ~href_s3_q;
  assign href_fall = ~href_s2_q & href_s3_q;
  assign vs_rise   = vs_s2_q & ~vs_s3_q;
  assign vs_fall   = ~vs_s2_q & vs_s3_q;

  // Frame/line sequencing, byte pairing and error detection.
  always_comb begin
    state_d       = state_q;
    tog_d         = tog_q;
    hi_d          = hi_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    pix_data_d    = pix_data_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    fs_d          = 1'b0;
    fe_d          = 1'b0;
    le_d          = 1'b0;
    set_err_line  = 1'b0;
    set_err_frame = 1'b0;
    // A line start in the same cycle as a byte makes that byte the first one.
    tog_cur       = href_rise ? 1'b0 : tog_q;
    pix_cnt_cur   = href_rise ? 10'd0 : pix_cnt_q;

    case (state_q)
      WAIT_SYNC: begin
        if (vs_rise) state_d = BLANK;
      end
      BLANK: begin
        if (vs_fall && enable) begin
          state_d    = ACTIVE;
          fs_d       = 1'b1;
          line_cnt_d = 9'd0;
          pix_cnt_d  = 10'd0;
          tog_d      = 1'b0;
        end
      end
      ACTIVE: begin
        tog_d     = tog_cur;
        pix_cnt_d = pix_cnt_cur;
        if (href_fall) begin
          // A dangling high byte is simply dropped by clearing the toggle.
          le_d  = 1'b1;
          tog_d = 1'b0;
          if (pix_cnt_q != H_LIM) set_err_line = 1'b1;
          if (line_cnt_q != V_LIM) line_cnt_d = line_cnt_q + 9'd1;
        end else if (pclk_rise && href_s2_q) begin
          if (!tog_cur) begin
            hi_d  = data_s2_q;
            tog_d = 1'b1;
          end else begin
            tog_d = 1'b0;
            if (pix_cnt_cur < H_LIM && line_cnt_q < V_LIM) begin
              pix_valid_d = 1'b1;
              pix_data_d  = {hi_q, data_s2_q};
              pix_x_d     = pix_cnt_cur;
              pix_cnt_d   = pix_cnt_cur + 10'd1;
            end else begin
              set_err_line = 1'b1;
            end
          end
        end
        if (vs_rise) begin
          state_d = BLANK;
          fe_d    = 1'b1;
          if (line_cnt_d != V_LIM) set_err_frame = 1'b1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase

    err_line_d  = (err_clr ? 1'b0 : err_line_q) | set_err_line;
    err_frame_d = (err_clr ? 1'b0 : err_frame_q) | set_err_frame;
  end

  // Register state, counters and outputs.
  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      state_q     <= WAIT_SYNC;
      tog_q       <= 1'b0;
      hi_q        <= 8'h00;
      pix_cnt_q   <= 10'd0;
      line_cnt_q  <= 9'd0;
      pix_data_q  <= 16'h0000;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 10'd0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      le_q        <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tog_q       <= tog_d;
      hi_q        <= hi_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      le_q        <= le_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = line_cnt_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign line_end    = le_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a reduced 4x3 window.
module tb_camera_capture;
  localparam int H = 4;
  localparam int V = 3;

  logic        inclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        apclk = 1'b0;
  logic        ahref = 1'b0;
  logic        avsync = 1'b0;
  logic [7:0]  adata = 8'h00;
  logic        err_clr = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        frame_start, frame_end, line_end, err_line, err_frame;

  int n_checks = 0;
  int n_fail = 0;
  int hp = 2;
  int cyc = 0;
  int n_le, n_fs, n_fe, le_cyc, fe_cyc;
  logic [15:0] q_data[$];
  logic [9:0]  q_x[$];
  logic [8:0]  q_y[$];

  camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .inclk(inclk), .rst_n(rst_n), .enable(enable), .apclk(apclk), .ahref(ahref),
    .avsync(avsync), .adata(adata), .err_clr(err_clr), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .frame_end(frame_end), .line_end(line_end), .err_line(err_line), .err_frame(err_frame)
  );

  always #5 inclk = ~inclk;

  always @(posedge inclk) cyc++;

  always @(negedge inclk) begin
    if (pix_valid) begin
      q_data.push_back(pix_data);
      q_x.push_back(pix_x);
      q_y.push_back(pix_y);
    end
    if (line_end) begin n_le++; le_cyc = cyc; end
    if (frame_start) n_fs++;
    if (frame_end) begin n_fe++; fe_cyc = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got cyc=%0d required finish", cyc);
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) @(negedge inclk);
  endtask

  task automatic clear_mon();
    q_data.delete(); q_x.delete(); q_y.delete();
    n_le = 0; n_fs = 0; n_fe = 0; le_cyc = -1; fe_cyc = -2;
  endtask

  task automatic send_byte(logic [7:0] b);
    adata = b; tick(hp); apclk = 1'b1; tick(hp); apclk = 1'b0;
  endtask

  task automatic send_bytes(int first, int n);
    for (int i = first; i < first + n; i++) send_byte(8'(i));
  endtask

  task automatic send_line(int nbytes);
    ahref = 1'b1; tick(2);
    send_bytes(0, nbytes);
    tick(1); ahref = 1'b0; tick(4);
  endtask

  task automatic send_frame(int nlines, int nbytes);
    avsync = 1'b0; tick(4);
    for (int l = 0; l < nlines; l++) send_line(nbytes);
    avsync = 1'b1; tick(4);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
  endtask

  // Reference model: pixels of line y, column x are bytes {2x, 2x+1}.
  function automatic int pixel_errors();
    int bad = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      int x;
      int y;
      logic [15:0] e;
      x = i % H;
      y = i / H;
      e = {8'(2 * x), 8'(2 * x + 1)};
      if (q_data[i] !== e || q_x[i] !== 10'(x) || q_y[i] !== 9'(y)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; avsync = 1'b1; ahref = 1'b1; apclk = 1'b1; tick(3);
    n_checks++; if (pix_data !== 16'h0) begin n_fail++; $display("FAIL rst_pix_data got=%h exp=0000", pix_data); end
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pix_valid got=%b exp=0", pix_valid); end
    n_checks++; if (pix_x !== 10'd0) begin n_fail++; $display("FAIL rst_pix_x got=%0d exp=0", pix_x); end
    n_checks++; if (pix_y !== 9'd0) begin n_fail++; $display("FAIL rst_pix_y got=%0d exp=0", pix_y); end
    n_checks++; if ({frame_start, frame_end, line_end} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses got=%b exp=000", {frame_start, frame_end, line_end}); end
    n_checks++; if ({err_line, err_frame} !== 2'b00) begin n_fail++; $display("FAIL rst_errs got=%b exp=00", {err_line, err_frame}); end
    avsync = 1'b0; ahref = 1'b0; apclk = 1'b0; tick(1);
    rst_n = 1'b1; tick(4);
  endtask

  task automatic test_no_capture_before_sync();
    clear_mon();
    send_line(8); send_line(8);
    n_checks++; if (q_data.size() !== 0) begin n_fail++; $display("FAIL presync_pix got=%0d exp=0", q_data.size()); end
    n_checks++; if (n_le !== 0) begin n_fail++; $display("FAIL presync_line_end got=%0d exp=0", n_le); end
    avsync = 1'b1; tick(4);
    send_frame(3, 8);
    n_checks++; if (q_data.size() !== 12) begin n_fail++; $display("FAIL frame_pix_count got=%0d exp=12", q_data.size()); end
    n_checks++; if (pixel_errors() !== 0) begin n_fail++; $display("FAIL frame_pixels got=%0d bad exp=0", pixel_errors()); end
    if (q_data.size() >= 4) begin
      n_checks++; if (q_data[0] !== 16'h0001) begin n_fail++; $display("FAIL first_pixel got=%h exp=0001", q_data[0]); end
      n_checks++; if (q_data[3] !== 16'h0607 || q_x[3] !== 10'd3) begin n_fail++; $display("FAIL last_col got=%h x=%0d exp=0607 x=3", q_data[3], q_x[3]); end
    end
    n_checks++; if (n_le !== 3) begin n_fail++; $display("FAIL frame_line_end got=%0d exp=3", n_le); end
    n_checks++; if (n_fs !== 1 || n_fe !== 1) begin n_fail++; $display("FAIL frame_pulses got fs=%0d fe=%0d exp 1 1", n_fs, n_fe); end
    n_checks++; if ({err_line, err_frame} !== 2'b00) begin n_fail++; $display("FAIL frame_errs got=%b exp=00", {err_line, err_frame}); end
  endtask

  task automatic test_latency();
    clear_mon();
    avsync = 1'b0; tick(4);
    ahref = 1'b1; tick(2);
    send_byte(8'h00);
    adata = 8'h01; tick(hp); apclk = 1'b1;
    @(posedge inclk); #1;
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c1 got=%b exp=0", pix_valid); end
    @(posedge inclk); #1;
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c2 got=%b exp=0", pix_valid); end
    @(posedge inclk); #1;
    n_checks++; if (pix_valid !== 1'b1 || pix_data !== 16'h0001) begin n_fail++; $display("FAIL lat_c3 got valid=%b data=%h exp 1 0001", pix_valid, pix_data); end
    @(posedge inclk); #1;
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL lat_c4 got=%b exp=0", pix_valid); end
    @(negedge inclk); apclk = 1'b0;
    send_bytes(2, 6); tick(1); ahref = 1'b0; tick(4);
    send_line(8); send_line(8);
    avsync = 1'b1; tick(4);
    n_checks++; if (q_data.size() !== 12) begin n_fail++; $display("FAIL lat_frame_pix got=%0d exp=12", q_data.size()); end
    n_checks++; if ({err_line, err_frame} !== 2'b00) begin n_fail++; $display("FAIL lat_errs got=%b exp=00", {err_line, err_frame}); end
  endtask

  task automatic test_short_line();
    clear_mon();
    avsync = 1'b0; tick(4);
    send_line(8);
    n_checks++; if (err_line !== 1'b0) begin n_fail++; $display("FAIL short_pre_err got=%b exp=0", err_line); end
    send_line(6);
    n_checks++; if (err_line !== 1'b1) begin n_fail++; $display("FAIL short_err got=%b exp=1", err_line); end
    n_checks++; if (q_data.size() !== 7) begin n_fail++; $display("FAIL short_pix got=%0d exp=7", q_data.size()); end
    send_line(8);
    avsync = 1'b1; tick(4);
    n_checks++; if (err_line !== 1'b1 || err_frame !== 1'b0) begin n_fail++; $display("FAIL short_sticky got line=%b frame=%b exp 1 0", err_line, err_frame); end
    n_checks++; if (q_data.size() !== 11) begin n_fail++; $display("FAIL short_total got=%0d exp=11", q_data.size()); end
    pulse_clr();
    n_checks++; if (err_line !== 1'b0) begin n_fail++; $display("FAIL short_clr got=%b exp=0", err_line); end
  endtask

  task automatic test_odd_line();
    clear_mon();
    avsync = 1'b0; tick(4);
    send_line(8); send_line(9); send_line(8);
    avsync = 1'b1; tick(4);
    n_checks++; if (q_data.size() !== 12) begin n_fail++; $display("FAIL odd_pix got=%0d exp=12", q_data.size()); end
    n_checks++; if (pixel_errors() !== 0) begin n_fail++; $display("FAIL odd_pixels got=%0d bad exp=0", pixel_errors()); end
    n_checks++; if ({err_line, err_frame} !== 2'b00) begin n_fail++; $display("FAIL odd_errs got=%b exp=00", {err_line, err_frame}); end
  endtask

  task automatic test_long_line();
    clear_mon();
    avsync = 1'b0; tick(4);
    send_line(8); send_line(10); send_line(8);
    avsync = 1'b1; tick(4);
    n_checks++; if (q_data.size() !== 12) begin n_fail++; $display("FAIL long_pix got=%0d exp=12", q_data.size()); end
    n_checks++; if (pixel_errors() !== 0) begin n_fail++; $display("FAIL long_pixels got=%0d bad exp=0", pixel_errors()); end
    n_checks++; if (err_line !== 1'b1) begin n_fail++; $display("FAIL long_err got=%b exp=1", err_line); end
    pulse_clr();
  endtask

  task automatic test_frame_lines();
    clear_mon();
    send_frame(2, 8);
    n_checks++; if (err_frame !== 1'b1 || n_fe !== 1) begin n_fail++; $display("FAIL short_frame got err=%b fe=%0d exp 1 1", err_frame, n_fe); end
    pulse_clr();
    n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL frame_clr got=%b exp=0", err_frame); end
    clear_mon();
    send_frame(4, 8);
    n_checks++; if (q_data.size() !== 12) begin n_fail++; $display("FAIL tall_pix got=%0d exp=12", q_data.size()); end
    n_checks++; if (err_line !== 1'b1 || err_frame !== 1'b0) begin n_fail++; $display("FAIL tall_errs got line=%b frame=%b exp 1 0", err_line, err_frame); end
    n_checks++; if (pix_y !== 9'd3) begin n_fail++; $display("FAIL tall_sat got=%0d exp=3", pix_y); end
    pulse_clr();
  endtask

  task automatic test_coincide();
    clear_mon();
    avsync = 1'b0; tick(4);
    send_line(8); send_line(8);
    ahref = 1'b1; tick(2);
    send_bytes(0, 8); tick(1);
    ahref = 1'b0; avsync = 1'b1; tick(4);
    n_checks++; if (n_le !== 3 || n_fe !== 1) begin n_fail++; $display("FAIL coin_counts got le=%0d fe=%0d exp 3 1", n_le, n_fe); end
    n_checks++; if (le_cyc !== fe_cyc) begin n_fail++; $display("FAIL coin_same_cycle got le=%0d fe=%0d exp equal", le_cyc, fe_cyc); end
    n_checks++; if (err_frame !== 1'b0 || q_data.size() !== 12) begin n_fail++; $display("FAIL coin_frame got err=%b pix=%0d exp 0 12", err_frame, q_data.size()); end
  endtask

  task automatic test_err_clr_collision();
    clear_mon();
    avsync = 1'b0; tick(4);
    ahref = 1'b1; tick(2);
    send_bytes(0, 6); tick(1);
    ahref = 1'b0;
    @(posedge inclk); @(posedge inclk);
    @(negedge inclk); err_clr = 1'b1;
    @(posedge inclk); #1;
    n_checks++; if (err_line !== 1'b1) begin n_fail++; $display("FAIL clr_collide got=%b exp=1", err_line); end
    @(negedge inclk); err_clr = 1'b0; tick(3);
    send_line(8); send_line(8);
    avsync = 1'b1; tick(4);
    pulse_clr();
    n_checks++; if ({err_line, err_frame} !== 2'b00) begin n_fail++; $display("FAIL clr_after got=%b exp=00", {err_line, err_frame}); end
  endtask

  task automatic test_enable();
    clear_mon();
    avsync = 1'b0; tick(4);
    send_line(8);
    enable = 1'b0;
    send_line(8); send_line(8);
    avsync = 1'b1; tick(4);
    n_checks++; if (n_fs !== 1 || n_fe !== 1 || q_data.size() !== 12) begin n_fail++; $display("FAIL en_finish got fs=%0d fe=%0d pix=%0d exp 1 1 12", n_fs, n_fe, q_data.size()); end
    clear_mon();
    send_frame(3, 8);
    n_checks++; if (n_fs !== 0 || q_data.size() !== 0 || n_le !== 0) begin n_fail++; $display("FAIL en_off got fs=%0d pix=%0d le=%0d exp 0 0 0", n_fs, q_data.size(), n_le); end
    enable = 1'b1;
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    avsync = 1'b0; tick(4);
    send_line(8); send_line(8);
    ahref = 1'b1; tick(2);
    send_bytes(0, 3);
    rst_n = 1'b0;
    @(posedge inclk); #1;
    n_checks++; if ({pix_valid, frame_start, frame_end, line_end, err_line, err_frame} !== 6'b0) begin n_fail++; $display("FAIL midrst_flags got=%b exp=000000", {pix_valid, frame_start, frame_end, line_end, err_line, err_frame}); end
    n_checks++; if (pix_data !== 16'h0 || pix_x !== 10'd0 || pix_y !== 9'd0) begin n_fail++; $display("FAIL midrst_data got d=%h x=%0d y=%0d exp 0 0 0", pix_data, pix_x, pix_y); end
    @(negedge inclk); rst_n = 1'b1;
    clear_mon();
    send_bytes(3, 5); tick(1); ahref = 1'b0; tick(4);
    avsync = 1'b1; tick(4);
    n_checks++; if (n_fe !== 0 || q_data.size() !== 0) begin n_fail++; $display("FAIL midrst_abandon got fe=%0d pix=%0d exp 0 0", n_fe, q_data.size()); end
    send_frame(3, 8);
    n_checks++; if (q_data.size() !== 12 || n_fs !== 1 || n_fe !== 1) begin n_fail++; $display("FAIL midrst_resume got pix=%0d fs=%0d fe=%0d exp 12 1 1", q_data.size(), n_fs, n_fe); end
    n_checks++; if (pixel_errors() !== 0) begin n_fail++; $display("FAIL midrst_pixels got=%0d bad exp=0", pixel_errors()); end
  endtask

  task automatic test_nominal_ratio();
    hp = 8;
    clear_mon();
    send_frame(3, 8);
    n_checks++; if (q_data.size() !== 12 || n_le !== 3) begin n_fail++; $display("FAIL x16_counts got pix=%0d le=%0d exp 12 3", q_data.size(), n_le); end
    n_checks++; if (pixel_errors() !== 0) begin n_fail++; $display("FAIL x16_pixels got=%0d bad exp=0", pixel_errors()); end
    hp = 2;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_no_capture_before_sync();
    test_latency();
    test_short_line();
    test_odd_line();
    test_long_line();
    test_frame_lines();
    test_coincide();
    test_err_clr_collision();
    test_enable();
    test_reset_midframe();
    test_nominal_ratio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 inclk  input  1  system clock, the only clock in the block; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  capture enable; 0 = stop capturing at the next frame boundary.
REQ-006 apclk  input  1  camera pixel clock (asynchronous, sampled as data).
REQ-007 ahref  input  1  camera line-valid, asynchronous.
REQ-008 avsync  input  1  camera frame sync, high during vertical blanking, asynchronous.
REQ-009 adata  input  8  camera byte bus, stable at the apclk rising edge.
REQ-010 err_clr  input  1  single-cycle pulse that clears the error flags.
REQ-011 pix_data  output  16  assembled RGB565 pixel, first byte in [15:8].
REQ-012 pix_valid  output  1  one-cycle strobe qualifying pix_data/pix_x/pix_y.
REQ-013 pix_x  output  10  column of the current pixel, 0..H_ACTIVE-1.
REQ-014 pix_y  output  9  row of the current pixel, 0..V_ACTIVE-1.
REQ-015 frame_start  output  1  one-cycle pulse at the avsync fall that begins a captured frame.
REQ-016 frame_end  output  1  one-cycle pulse at the avsync rise that ends a captured frame.
REQ-017 line_end  output  1  one-cycle pulse at each ahref fall inside a captured frame.
REQ-018 err_line  output  1  sticky flag: line length mismatch or pixel outside the window.
REQ-019 err_frame  output  1  sticky flag: line count at frame_end differs from V_ACTIVE.

Function
REQ-020 apclk, ahref, avsync and adata SHALL each pass through a 2-flop synchronizer (s1, s2), plus a third register s3 for the edge detect.
REQ-021 Rise and fall events SHALL be decoded from s2 versus s3; all decisions SHALL use the s2 copies only.
REQ-022 The design SHALL work for inclk at 4x apclk or faster; 16x is the nominal ratio.
REQ-023 The state machine SHALL have three states: WAIT_SYNC, BLANK and ACTIVE.
REQ-024 WAIT_SYNC -> BLANK on an avsync rise; this prevents capture from starting mid-frame.
REQ-025 BLANK -> ACTIVE on an avsync fall when enable=1; frame_start pulses; pix_y and the line counter clear to 0.
REQ-026 ACTIVE -> BLANK on an avsync rise; frame_end pulses.
REQ-027 At frame_end, err_frame SHALL set if lines captured != V_ACTIVE.
REQ-028 If enable=0, the block SHALL stay in BLANK; enable changes SHALL take effect only at a frame boundary.
REQ-029 In ACTIVE with ahref=1, each apclk rise SHALL latch one byte.
REQ-030 A byte toggle, cleared on an ahref rise, SHALL select the byte: even byte -> high-byte register, odd byte -> forms pix_data and pulses pix_valid.
REQ-031 Latency: pix_valid SHALL assert exactly 3 inclk cycles after the cycle in which s1 first samples the apclk rise of the second byte.
REQ-032 pix_x SHALL be 0 on the first pixel after an ahref rise and increment by 1 per pix_valid.
REQ-033 On an ahref fall in ACTIVE, line_end SHALL pulse and pix_y SHALL increment.
REQ-034 On an ahref fall in ACTIVE, err_line SHALL set if the pixel count != H_ACTIVE.
REQ-035 On an ahref fall in ACTIVE, a pending odd high byte SHALL be discarded with no pix_valid.
REQ-036 Pixels with column >= H_ACTIVE or line >= V_ACTIVE SHALL be dropped (no pix_valid), and err_line SHALL set.
REQ-037 The pixel counter SHALL saturate at H_ACTIVE; the line counter SHALL saturate at V_ACTIVE; neither SHALL wrap.
REQ-038 An ahref edge or apclk rise outside ACTIVE SHALL be ignored.
REQ-039 If an avsync rise coincides with an ahref fall, line_end and frame_end SHALL both pulse in the same cycle.
REQ-040 If err_clr coincides with a new error event, the set SHALL win.

Reset
REQ-041 While rst_n=0 at an inclk edge: state = WAIT_SYNC; all synchronizer flops = 0.
REQ-042 While rst_n=0: pix_data = 0, pix_valid = 0, pix_x = 0, pix_y = 0, frame_start = 0, frame_end = 0, line_end = 0, err_line = 0, err_frame = 0.
REQ-043 A reset asserted mid-frame SHALL abandon the frame; capture SHALL resume only after the next avsync rise then fall.

Verification
REQ-044 Full frame: 640x480, 1280 bytes per line, inclk = 16x apclk, bytes 00,01,02,... per line -> 307200 pix_valid; first pixel pix_data=16'h0001 at x=0,y=0; pixel 639 = 16'hFEFF at x=639; 480 line_end; one frame_start and one frame_end; no error flags set.
REQ-045 Start after reset with avsync low and ahref toggling -> no pix_valid until an avsync rise then fall; then normal capture.
REQ-046 Short line of 1278 bytes -> 639 pix_valid on that line; err_line=1 at the ahref fall; err_line stays 1 until err_clr, then reads 0.
REQ-047 Odd line of 1281 bytes -> 640 pix_valid; last byte discarded; err_line=0.
REQ-048 Frame of 479 lines -> err_frame=1 at frame_end; enable dropped mid-frame -> current frame completes and the next frame produces no frame_start.
REQ-049 rst_n low for 1 cycle at line 200 -> all outputs 0 on the next cycle; the next full frame captures 307200 pixels with pix_y starting at 0.
